// File: rtl/pulse_freq_meter.sv
// rtl/pulse_freq_meter.sv - averaged period / high-time meter for an async pulse train
module pulse_freq_meter #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 10_000_000,
    parameter int AVG_LOG = 2
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             signal_lost
);

    localparam int ACC_W = CNT_W + AVG_LOG;
    localparam int SMP_W = AVG_LOG + 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG) - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [ACC_W-1:0] p_acc_q, p_acc_d;
    logic [ACC_W-1:0] h_acc_q, h_acc_d;
    logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             signal_lost_q, signal_lost_d;

    logic             rise;
    logic [CNT_W-1:0] p_sample;
    logic [ACC_W-1:0] p_sum;
    logic [ACC_W-1:0] h_sum;

    always_comb begin
        state_d       = state_q;
        s1_d          = pulse_in;
        s2_d          = s1_q;
        s3_d          = s2_q;
        per_cnt_d     = per_cnt_q;
        hi_cnt_d      = hi_cnt_q;
        p_acc_d       = p_acc_q;
        h_acc_d       = h_acc_q;
        smp_cnt_d     = smp_cnt_q;
        period_d      = period_q;
        high_time_d   = high_time_q;
        meas_valid_d  = 1'b0;
        signal_lost_d = signal_lost_q;

        rise     = s2_q & ~s3_q;
        // per_cnt never exceeds TIMEOUT-1, so the +1 sample always fits CNT_W
        p_sample = per_cnt_q + CNT_W'(1);
        p_sum    = p_acc_q + ACC_W'(p_sample);
        h_sum    = h_acc_q + ACC_W'(hi_cnt_q);

        case (state_q)
            IDLE: begin
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                p_acc_d   = '0;
                h_acc_d   = '0;
                smp_cnt_d = '0;
                if (rise) begin
                    hi_cnt_d      = CNT_W'(1);
                    signal_lost_d = 1'b0;
                    state_d       = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    per_cnt_d = '0;
                    hi_cnt_d  = CNT_W'(1);
                    if (smp_cnt_q == SMP_LAST) begin
                        period_d     = CNT_W'(p_sum >> AVG_LOG);
                        high_time_d  = CNT_W'(h_sum >> AVG_LOG);
                        meas_valid_d = 1'b1;
                        p_acc_d      = '0;
                        h_acc_d      = '0;
                        smp_cnt_d    = '0;
                    end else begin
                        p_acc_d   = p_sum;
                        h_acc_d   = h_sum;
                        smp_cnt_d = smp_cnt_q + SMP_W'(1);
                    end
                end else if (per_cnt_q == TO_LAST) begin
                    state_d       = IDLE;
                    signal_lost_d = 1'b1;
                    per_cnt_d     = '0;
                    hi_cnt_d      = '0;
                    p_acc_d       = '0;
                    h_acc_d       = '0;
                    smp_cnt_d     = '0;
                end else begin
                    per_cnt_d = per_cnt_q + CNT_W'(1);
                    if (s2_q) begin
                        hi_cnt_d = hi_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            per_cnt_q     <= '0;
            hi_cnt_q      <= '0;
            p_acc_q       <= '0;
            h_acc_q       <= '0;
            smp_cnt_q     <= '0;
            period_q      <= '0;
            high_time_q   <= '0;
            meas_valid_q  <= 1'b0;
            signal_lost_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            per_cnt_q     <= per_cnt_d;
            hi_cnt_q      <= hi_cnt_d;
            p_acc_q       <= p_acc_d;
            h_acc_q       <= h_acc_d;
            smp_cnt_q     <= smp_cnt_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            meas_valid_q  <= meas_valid_d;
            signal_lost_q <= signal_lost_d;
        end
    end

    assign period      = period_q;
    assign high_time   = high_time_q;
    assign meas_valid  = meas_valid_q;
    assign signal_lost = signal_lost_q;

endmodule

// File: tb/tb_pulse_freq_meter.sv
// tb/tb_pulse_freq_meter.sv - directed self-checking bench for pulse_freq_meter
module tb_pulse_freq_meter;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        pulse_in;
    logic [23:0] period_a, high_a, period_b, high_b;
    logic        valid_a, lost_a, valid_b, lost_b;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int c;
        int p;
        int h;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    pulse_freq_meter #(.CNT_W(24), .TIMEOUT(1000), .AVG_LOG(2)) u_dut_a (
        .sysclk     (sysclk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .period     (period_a),
        .high_time  (high_a),
        .meas_valid (valid_a),
        .signal_lost(lost_a)
    );

    pulse_freq_meter #(.CNT_W(24), .TIMEOUT(1000), .AVG_LOG(0)) u_dut_b (
        .sysclk     (sysclk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .period     (period_b),
        .high_time  (high_b),
        .meas_valid (valid_b),
        .signal_lost(lost_b)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        ev_t e;
        if (valid_a) begin
            e.c = cyc; e.p = int'(period_a); e.h = int'(high_a);
            qa.push_back(e);
        end
        if (valid_b) begin
            e.c = cyc; e.p = int'(period_b); e.h = int'(high_b);
            qb.push_back(e);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_period(input int len, input int hi, output int start);
        start = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge sysclk);
            #1;
            pulse_in = (i < hi);
            if (i == 0) start = cyc;
        end
    endtask

    task automatic wait_cyc(input int t);
        do @(negedge sysclk); while (cyc < t);
    endtask

    initial begin
        int c0, c2, c4, c5, c6, c7, s, nb;

        reset    = 1'b1;
        pulse_in = 1'b0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_period", int'(period_a), 0);
        chk("rst_high", int'(high_a), 0);
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_lost", int'(lost_a), 0);
        @(posedge sysclk);
        #1 reset = 1'b0;

        // steady 100/50 train: strobes one cycle after rises 5, 9, 13
        drive_period(100, 50, c0);
        repeat (12) drive_period(100, 50, s);
        chk("t1_count", qa.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < qa.size()) begin
                chk($sformatf("t1_cyc%0d", i), qa[i].c, c0 + 403 + 400 * i);
                chk($sformatf("t1_per%0d", i), qa[i].p, 100);
                chk($sformatf("t1_hi%0d", i), qa[i].h, 50);
            end
        end

        // last rise visible at c0+1202; timeout raises signal_lost 1001 cycles later
        wait_cyc(c0 + 1200 + 1002);
        chk("t3_lost_before", int'(lost_a), 0);
        wait_cyc(c0 + 1200 + 1003);
        chk("t3_lost_after", int'(lost_a), 1);
        chk("t3_no_strobe", qa.size(), 3);
        chk("t3_per_hold", int'(period_a), 100);
        chk("t3_hi_hold", int'(high_a), 50);

        nb = qa.size();
        drive_period(99, 30, c2);
        chk("t2_lost_clear", int'(lost_a), 0);
        drive_period(101, 30, s);
        drive_period(100, 30, s);
        drive_period(102, 30, s);

        // rises exactly TIMEOUT apart land on per_cnt == TIMEOUT-1
        drive_period(1000, 10, c4);
        repeat (3) drive_period(1000, 10, s);
        chk("t4_lost", int'(lost_a), 0);
        chk("t2_count", qa.size() - nb, 1);
        if (qa.size() > nb) begin
            chk("t2_cyc", qa[nb].c, c2 + 405);
            chk("t2_per", qa[nb].p, 100);
            chk("t2_hi", qa[nb].h, 30);
        end

        nb = qa.size();
        drive_period(100, 50, c5);
        drive_period(100, 50, s);
        drive_period(100, 50, s);
        chk("t4_count", qa.size() - nb, 1);
        if (qa.size() > nb) begin
            chk("t4_cyc", qa[nb].c, c5 + 3);
            chk("t4_per", qa[nb].p, 1000);
            chk("t4_hi", qa[nb].h, 10);
        end
        chk("t4_lost_end", int'(lost_a), 0);

        // async reset with two samples accumulated
        @(posedge sysclk);
        #3;
        reset    = 1'b1;
        pulse_in = 1'b0;
        #1;
        chk("t5_per_async", int'(period_a), 0);
        chk("t5_hi_async", int'(high_a), 0);
        chk("t5_valid_async", int'(valid_a), 0);
        chk("t5_perb_async", int'(period_b), 0);
        repeat (2) @(posedge sysclk);
        #1 reset = 1'b0;

        nb = qa.size();
        drive_period(100, 50, c6);
        repeat (4) drive_period(100, 50, s);
        chk("t5_count", qa.size() - nb, 1);
        if (qa.size() > nb) begin
            chk("t5_cyc", qa[nb].c, c6 + 403);
            chk("t5_per", qa[nb].p, 100);
            chk("t5_hi", qa[nb].h, 50);
        end
        wait_cyc(c6 + 400 + 1010);
        chk("t5_lost_a", int'(lost_a), 1);
        chk("t5_lost_b", int'(lost_b), 1);

        // period 4 / high 1 without averaging: a strobe per period
        nb = qb.size();
        drive_period(4, 1, c7);
        repeat (9) drive_period(4, 1, s);
        wait_cyc(c7 + 42);
        chk("t6_count", qb.size() - nb, 9);
        for (int i = 0; i < 9; i++) begin
            if (nb + i < qb.size()) begin
                chk($sformatf("t6_cyc%0d", i), qb[nb + i].c, c7 + 4 * (i + 1) + 3);
                chk($sformatf("t6_per%0d", i), qb[nb + i].p, 4);
                chk($sformatf("t6_hi%0d", i), qb[nb + i].h, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
